// File: rtl/flp32_addsub_arbiter_pkg.sv
// flp32_addsub_arbiter_pkg: shared FP32 types, op encodings and the add/sub core
package flp32_addsub_arbiter_pkg;
    typedef logic [31:0] flp32_t;
    localparam logic FLP_OP_ADD = 1'b0;
    localparam logic FLP_OP_SUB = 1'b1;
    // Round-to-nearest-even IEEE-754 single add; subtraction is done by the caller flipping b's sign.
    function automatic flp32_t flp32_add(input flp32_t a, input flp32_t b);
        flp32_t l, s;
        logic [7:0] el, es, d;
        logic [26:0] ml, ms0, ms, n;
        logic [27:0] sum;
        logic [8:0] e, lz, sh;
        logic [24:0] r;
        logic up;
        if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
            if ((a[30:23] == 8'hff && a[22:0] != '0) || (b[30:23] == 8'hff && b[22:0] != '0) ||
                (a[30:23] == 8'hff && b[30:23] == 8'hff && a[31] != b[31]))
                return 32'h7fc00000;
            return a[30:23] == 8'hff ? a : b;
        end
        l = (b[30:0] > a[30:0]) ? b : a;
        s = (b[30:0] > a[30:0]) ? a : b;
        el = (l[30:23] == '0) ? 8'd1 : l[30:23];
        es = (s[30:23] == '0) ? 8'd1 : s[30:23];
        d = el - es;
        ml = {|l[30:23], l[22:0], 3'b0};
        ms0 = {|s[30:23], s[22:0], 3'b0};
        // Bits shifted out of the guard window collapse into a sticky LSB.
        ms = (d >= 8'd27) ? {26'b0, |ms0} : ((ms0 >> d) | {26'b0, |(ms0 & ~(27'h7ffffff << d))});
        sum = (l[31] ^ s[31]) ? {1'b0, ml} - {1'b0, ms} : {1'b0, ml} + {1'b0, ms};
        if (sum == '0)
            return {l[31] & s[31], 31'b0};
        e = {1'b0, el};
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 9'd1;
        end else begin
            lz = 9'd27;
            for (int i = 0; i < 27; i++)
                if (sum[i]) lz = 9'(26 - i);
            // Never normalise below the minimum exponent; the remainder becomes a denormal.
            sh = (lz > e - 9'd1) ? e - 9'd1 : lz;
            n = sum[26:0] << sh;
            e = e - sh;
        end
        up = n[2] & (n[1] | n[0] | n[3]);
        r = {1'b0, n[26:3]} + 25'(up);
        if (r[24])
            e = e + 9'd1;
        if (e >= 9'd255)
            return {l[31], 8'hff, 23'b0};
        return {l[31], (r[24] | r[23]) ? e[7:0] : 8'd0, r[24] ? r[23:1] : r[22:0]};
    endfunction
endpackage

// File: rtl/flp32_add_sub.sv
// flp32_add_sub: combinational IEEE-754 single-precision X+Y and X-Y
//   X, Y        operands
//   Result_Add  X+Y
//   Result_Sub  X-Y
module flp32_add_sub
    import flp32_addsub_arbiter_pkg::*;
(
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic [31:0] Result_Add,
    output logic [31:0] Result_Sub
);
    assign Result_Add = flp32_add(X, Y);
    assign Result_Sub = flp32_add(X, {~Y[31], Y[30:0]});
endmodule

// File: rtl/flp32_addsub_arbiter.sv
// flp32_addsub_arbiter: round-robin sharing of one flp32_add_sub among N_REQ requesters
//   clk, rst             clock, async active-high reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_op, req_x, req_y per-requester op (1 = X-Y) and packed 32-bit operands
//   res_valid/res_ready  single-entry output buffer handshake
//   res_data, res_id     buffered result and the index of its requester
module flp32_addsub_arbiter
    import flp32_addsub_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_op,
    input  logic [N_REQ*32-1:0]  req_x,
    input  logic [N_REQ*32-1:0]  req_y,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    output logic [31:0]          res_data,
    output logic [ID_W-1:0]      res_id,
    input  logic                 res_ready
);
    logic            res_valid_q, res_valid_d;
    logic [31:0]     res_data_q, res_data_d;
    logic [ID_W-1:0] res_id_q, res_id_d, rr_ptr_q, rr_ptr_d, win;
    logic            found, grant;
    flp32_t          x, y, sum_add, sum_sub;
    // Scan from rr_ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                win = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end
    // The buffer is bypassed: a draining result frees the slot in the same cycle.
    assign grant = !rst && found && (!res_valid_q || res_ready);
    assign req_ready = grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;
    assign x = req_x[int'(win)*32 +: 32];
    assign y = req_y[int'(win)*32 +: 32];
    flp32_add_sub u_add_sub (
        .X          (x),
        .Y          (y),
        .Result_Add (sum_add),
        .Result_Sub (sum_sub)
    );
    always_comb begin
        res_valid_d = grant | (res_valid_q & ~res_ready);
        res_data_d = grant ? ((req_op[win] == FLP_OP_SUB) ? sum_sub : sum_add) : res_data_q;
        res_id_d = grant ? win : res_id_q;
        rr_ptr_d = !grant ? rr_ptr_q : (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q <= '0;
            res_id_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q <= res_data_d;
            res_id_q <= res_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
    assign res_valid = res_valid_q;
    assign res_data = res_data_q;
    assign res_id = res_id_q;
endmodule

// File: tb/tb_flp32_addsub_arbiter.sv
// tb_flp32_addsub_arbiter: scoreboard bench for the shared FP32 add/sub arbiter
module tb_flp32_addsub_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_op = '0;
    logic [127:0] req_x = '0;
    logic [127:0] req_y = '0;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic [31:0]  res_data;
    logic [1:0]   res_id;
    logic         res_ready = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] tx   [5] = '{32'h43E40000, 32'h3F800000, 32'h3FC00000, 32'h40400000, 32'hC0200000};
    logic [31:0] ty   [5] = '{32'h4410C000, 32'h40000000, 32'h3F000000, 32'h40400000, 32'h3FA00000};
    logic [31:0] tadd [5] = '{32'h44816000, 32'h40400000, 32'h40000000, 32'h40C00000, 32'hBFA00000};
    logic [31:0] tsub [5] = '{32'hC2F60000, 32'hBF800000, 32'h3F800000, 32'h00000000, 32'hC0700000};
    int vec_sel [4] = '{0, 0, 0, 0};
    logic [33:0] sb [$];
    int  exp_ptr = 0;
    bit  model_valid = 0;
    flp32_addsub_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] exp_data(input int i);
        return req_op[i] ? tsub[vec_sel[i]] : tadd[vec_sel[i]];
    endfunction
    // Reference model: predicts grants, pushes expected results, checks them when they drain.
    always @(negedge clk) begin
        bit found, grant;
        int w;
        logic [3:0] rdy;
        logic [33:0] e;
        if (rst) begin
            sb.delete();
            model_valid = 0;
            exp_ptr = 0;
        end else begin
            found = 0;
            w = 0;
            for (int k = 0; k < 4; k++)
                if (!found && req_valid[(exp_ptr + k) % 4]) begin
                    found = 1;
                    w = (exp_ptr + k) % 4;
                end
            grant = found && (!model_valid || res_ready);
            rdy = grant ? 4'(1 << w) : 4'b0;
            checks++;
            if (req_ready !== rdy) begin
                errors++;
                $display("FAIL sb_req_ready got %b want %b at %0t", req_ready, rdy, $time);
            end
            checks++;
            if (res_valid !== model_valid) begin
                errors++;
                $display("FAIL sb_res_valid got %b want %b at %0t", res_valid, model_valid, $time);
            end
            if (model_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow no expected result at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    if ({res_id, res_data} !== e) begin
                        errors++;
                        $display("FAIL sb_result got id %0d data %h want id %0d data %h", res_id, res_data, e[33:32], e[31:0]);
                    end
                end
            end
            if (grant) begin
                sb.push_back({2'(w), exp_data(w)});
                exp_ptr = (w + 1) % 4;
                model_valid = 1;
            end else if (res_ready) model_valid = 0;
        end
    end
    task automatic set_req(input int i, input logic v, input logic op, input int vs);
        req_valid[i] = v;
        req_op[i] = op;
        vec_sel[i] = vs;
        req_x[32*i +: 32] = tx[vs];
        req_y[32*i +: 32] = ty[vs];
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        req_valid = '0;
        res_ready = 1'b1;
        repeat (n) step();
    endtask
    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask
    task automatic test_reset();
        apply_reset();
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'h0 || res_id !== 2'd0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset got v%b d%h id%0d rdy%b want 0", res_valid, res_data, res_id, req_ready);
        end
    endtask
    task automatic test_single_add();
        set_req(0, 1'b1, 1'b0, 0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL add_ready got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h44816000 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL add_result got v%b %h id%0d want 1 44816000 id0", res_valid, res_data, res_id);
        end
        idle(2);
    endtask
    task automatic test_single_sub();
        set_req(2, 1'b1, 1'b1, 0);
        step();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'hC2F60000 || res_id !== 2'd2) begin
            errors++;
            $display("FAIL sub_result got v%b %h id%0d want 1 c2f60000 id2", res_valid, res_data, res_id);
        end
        idle(2);
    endtask
    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'(i & 1), i + 1);
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'(k % 4) || res_data !== exp_data(k % 4)) begin
                errors++;
                $display("FAIL rr_seq[%0d] got v%b id%0d %h want id%0d %h", k, res_valid, res_id, res_data, k % 4, exp_data(k % 4));
            end
        end
        idle(2);
    endtask
    task automatic test_back_pressure();
        int p;
        p = exp_ptr;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'(~i & 1), 4 - i);
        res_ready = 1'b0;
        step();
        repeat (3) begin
            checks++;
            if (req_ready !== 4'b0 || res_valid !== 1'b1 || res_id !== 2'(p) || res_data !== exp_data(p)) begin
                errors++;
                $display("FAIL bp_hold got rdy%b v%b id%0d %h want 0000 1 id%0d %h", req_ready, res_valid, res_id, res_data, p, exp_data(p));
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'(1 << ((p + 1) % 4))) begin
            errors++;
            $display("FAIL bp_release got %b want %b", req_ready, 4'(1 << ((p + 1) % 4)));
        end
        step();
        checks++;
        if (res_id !== 2'((p + 1) % 4)) begin
            errors++;
            $display("FAIL bp_next_id got %0d want %0d", res_id, (p + 1) % 4);
        end
        idle(2);
    endtask
    task automatic test_back_to_back_wrap();
        set_req(2, 1'b1, 1'b0, 3);
        step();
        idle(1);
        req_valid = '0;
        set_req(3, 1'b1, 1'b1, 3);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_grant3 got %b want 1000", req_ready);
        end
        step();
        req_valid = '0;
        set_req(0, 1'b1, 1'b0, 4);
        #1;
        checks++;
        if (req_ready !== 4'b0001 || res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_grant0 got rdy%b v%b id%0d %h want 0001 1 id3 00000000", req_ready, res_valid, res_id, res_data);
        end
        step();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 32'hBFA00000) begin
            errors++;
            $display("FAIL wrap_result got v%b id%0d %h want 1 id0 bfa00000", res_valid, res_id, res_data);
        end
        idle(2);
    endtask
    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 1);
        step();
        step();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'h0 || res_id !== 2'd0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL arst_clear got v%b %h id%0d rdy%b want 0 0 0 0000", res_valid, res_data, res_id, req_ready);
        end
        @(posedge clk);
        #2;
        req_valid = '0;
        set_req(1, 1'b1, 1'b1, 2);
        set_req(0, 1'b1, 1'b0, 2);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL arst_first_grant got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 32'h40000000) begin
            errors++;
            $display("FAIL arst_result got v%b id%0d %h want 1 id0 40000000", res_valid, res_id, res_data);
        end
        idle(3);
    endtask
    initial begin
        test_reset();
        test_single_add();
        test_single_sub();
        test_round_robin();
        test_back_pressure();
        test_back_to_back_wrap();
        test_async_reset();
        checks++;
        if (sb.size() != 0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got %0d pending v%b want 0", sb.size(), res_valid);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flp32_addsub_arbiter.md
Name: flp32_addsub_arbiter

Overview:
Shares one combinational flp32_add_sub datapath among N_REQ requesters, each issuing single-precision add or subtract operations.
- Round-robin arbitration over the requesters, one grant per cycle.
- Per-requester valid/ready handshake on input.
- Registers the selected result with the winning requester's index into a single-entry output buffer with valid/ready back-pressure.
- Sits between the filter/accumulate control blocks and the shared FP adder.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index (clog2(N_REQ), min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has an operation pending.
- req_op  in  N_REQ  bit i: 0 = X+Y, 1 = X-Y.
- req_x  in  N_REQ*32  operand X of requester i at bits [32i+31:32i], IEEE-754 single.
- req_y  in  N_REQ*32  operand Y of requester i, same packing.
- req_ready  out  N_REQ  one-hot (or zero) accept; a transfer occurs on req_valid[i] & req_ready[i].
- res_valid  out  1  output buffer holds a result.
- res_data  out  32  result (`BITS_RANGE).
- res_id  out  ID_W  index of the requester that owns res_data.
- res_ready  in  1  consumer accepts result this cycle.

Behaviour:
- Reset (async, immediate):
  - res_valid=0, res_data=0, res_id=0, rr_ptr=0.
  - req_ready is combinational and therefore 0 while the buffer logic is held in reset.
- Buffer state: EMPTY (res_valid=0) / FULL (res_valid=1).
- can_accept = ~res_valid | res_ready. Combinational, so the buffer is bypassed for throughput and a full-rate stream is possible.
- Arbitration:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - req_ready[winner] = can_accept; all other req_ready bits are 0.
  - No valid request: req_ready = 0.
  - req_ready must not depend on the requester's own operand values. It may depend on req_valid.
- Accept cycle t (req_valid[w] & req_ready[w]):
  - Drive X = req_x[w] and Y = req_y[w] into flp32_add_sub.
  - At edge t: res_data ← (req_op[w] ? Result_Sub : Result_Add), res_id ← w, res_valid ← 1, rr_ptr ← (w+1) mod N_REQ.
  - Latency is exactly 1 cycle: result is visible after edge t.
- Drain without new accept (res_valid & res_ready & no grant): res_valid ← 0 at the edge; res_data and res_id hold their values.
- Simultaneous drain and accept: the buffer is overwritten with the new result and res_valid stays 1. No bubble.
- FULL & ~res_ready:
  - All req_ready = 0.
  - res_data and res_id stay stable.
  - rr_ptr does not change.
- rr_ptr changes only on an accept. Wrap: w = N_REQ-1 → rr_ptr = 0.
- Fairness: a continuously valid requester is granted within N_REQ accepts.
- Arithmetic: operations are passed through flp32_add_sub unmodified. No rounding or exception handling is added here.
- Reset asserted mid-stream: the buffered result is discarded. Requesters must re-present after reset deasserts. The first grant after reset starts the scan at requester 0.

Decomposition:
- params.v (shared): `BITS_RANGE ([31:0]), plus new defines `FLP_OP_ADD (1'b0) and `FLP_OP_SUB (1'b1).
- Submodule: one instance of the existing flp32_add_sub(X, Y, Result_Add, Result_Sub).
- The round-robin priority pick is a combinational function or generate loop inside this module; it is not a separate module.

Test Plan:
- Single add: after reset, req_valid=0001, req_op[0]=0, X0=0x43E40000 (456), Y0=0x4410C000 (579), res_ready=1 → req_ready=0001 in the same cycle; next cycle res_valid=1, res_data=0x44816000 (1035), res_id=0.
- Single sub: requester 2 with the same operands, req_op[2]=1 → res_data=0xC2F60000 (-123), res_id=2, one-cycle latency.
- Round-robin: all four requesters valid continuously, res_ready=1 → grants in order 0,1,2,3,0,…, one per cycle; res_id follows the same sequence with no bubbles.
- Back-pressure: buffer full, res_ready=0 for 3 cycles → req_ready=0000, res_data and res_id stable, rr_ptr unchanged; on res_ready=1, the pending winner is accepted in that same cycle.
- Simultaneous drain+accept and wrap: rr_ptr=3, only requester 3 valid and then only 0 valid → grants 3, then 0; res_valid stays high across the back-to-back transfers.
- Async reset mid-stream: assert rst between clock edges while res_valid=1 → res_valid drops immediately, res_data=0; after release with requesters 1 and 0 valid, the first grant goes to 0.
